// File: rtl/mac_ctrl_pkg.sv
// Shared types and sizing for the MAC job sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mac_ctrl_pkg;

  localparam int BW      = 8;                  // operand lane width
  localparam int PR      = 8;                  // lanes per chunk
  localparam int PSUM_BW = 2*BW + 6;           // MAC output width
  localparam int LEN_BW  = 8;                  // job length field width
  localparam int MAC_LAT = 4;                  // MAC pipeline latency
  localparam int ACC_BW  = PSUM_BW + LEN_BW;   // accumulator width, cannot overflow
  localparam int OP_W    = PR * BW;            // packed chunk width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sign-extend one MAC partial sum to accumulator width.
  function automatic logic [ACC_BW-1:0] sext_psum(input logic [PSUM_BW-1:0] p);
    return {{(ACC_BW-PSUM_BW){p[PSUM_BW-1]}}, p};
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream and result stream between fetch logic and the MAC sequencer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on operands, res_valid/res_ready on the result.
// Ports: master = operand producer / result consumer, slave = sequencer.
interface mac_seq_ctrl_if;
  import mac_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_BW-1:0] result;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, result
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, result
  );

endinterface

// File: rtl/mac_vld_pipe.sv
// Shift register of valid bits that shadows data travelling through the MAC.
// Latency: DEPTH clk edges from push to tail.
// Backpressure: none, shifts every cycle.
// Ports: clk/reset, push (bit entering), tail (bit leaving), empty (no bit in flight).
module mac_vld_pipe #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  output logic tail,
  output logic empty
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe <= '0;
    else        pipe <= {pipe[DEPTH-2:0], push};
  end

  assign tail  = pipe[DEPTH-1];
  assign empty = ~|pipe;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one dot-product job (len chunks) through the 8-lane MAC and returns the sum.
// Latency: len + MAC_LAT + 2 cycles from first operand handshake to res_valid.
// Backpressure: in_ready only in ISSUE, zeros driven on bubbles; result held until res_ready.
// Ports: clk, reset (async active-low), start/len job request, bus (operand + result streams),
//        mac_a/mac_b/mac_reset/mac_out to the MAC array, busy (not IDLE).
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_BW-1:0]  len,
  mac_seq_ctrl_if.slave      bus,
  output logic [OP_W-1:0]    mac_a,
  output logic [OP_W-1:0]    mac_b,
  output logic               mac_reset,
  input  logic [PSUM_BW-1:0] mac_out,
  output logic               busy
);

  state_t                   state;
  state_t                   state_nxt;
  logic [LEN_BW-1:0]        len_q;
  logic [LEN_BW-1:0]        iss_cnt;
  logic signed [ACC_BW-1:0] acc;
  logic                     hs;
  logic                     last_iss;
  logic                     op_vld;
  logic                     pipe_tail;
  logic                     pipe_empty;
  logic                     drain_done;
  logic                     rel_q;

  assign hs       = (state == ISSUE) && bus.in_valid;
  // len_q >= 1 whenever ISSUE is reachable, so len_q-1 never wraps here.
  assign last_iss = hs && (iss_cnt == len_q - LEN_BW'(1));

  // op_vld marks the chunk sitting in mac_a/mac_b. The MAC registers its inputs
  // before its MAC_LAT stages, so the shadow pipe is MAC_LAT+1 deep behind it.
  mac_vld_pipe #(.DEPTH(MAC_LAT + 1)) u_vld_pipe (
    .clk   (clk),
    .reset (reset),
    .push  (op_vld),
    .tail  (pipe_tail),
    .empty (pipe_empty)
  );

  // Nothing left in the operand stage or MAC; the tail add has already landed.
  assign drain_done = !op_vld && pipe_empty;

  // MAC reset: held while reset is low, then for the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rel_q <= 1'b0;
    else        rel_q <= 1'b1;
  end
  assign mac_reset = ~rel_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? DONE : ISSUE;
      ISSUE: if (last_iss) state_nxt = DRAIN;
      DRAIN: if (drain_done) state_nxt = DONE;
      DONE:  if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      ISSUE:   bus.in_ready = 1'b1;
      DONE:    bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  // acc only changes while chunks are in flight, so result is stable in DONE.
  assign bus.result = acc;

  // Operand registers, issue counter, accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      iss_cnt <= '0;
      acc     <= '0;
      mac_a   <= '0;
      mac_b   <= '0;
      op_vld  <= 1'b0;
    end else begin
      mac_a  <= hs ? bus.in_a : '0;
      mac_b  <= hs ? bus.in_b : '0;
      op_vld <= hs;
      if ((state == IDLE) && start) begin
        len_q   <= len;
        iss_cnt <= '0;
        acc     <= '0;
      end else begin
        if (hs)        iss_cnt <= iss_cnt + LEN_BW'(1);
        if (pipe_tail) acc     <= acc + sext_psum(mac_out);
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural 8-lane MAC model.
// Latency: n/a.
// Backpressure: bench drives in_valid/res_ready patterns directly.
module tb_mac_seq_ctrl;
  import mac_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [LEN_BW-1:0]  len = '0;
  logic [OP_W-1:0]    mac_a;
  logic [OP_W-1:0]    mac_b;
  logic               mac_reset;
  logic [PSUM_BW-1:0] mac_out;
  logic               busy;
  int                 cyc = 0;
  int                 n_chk = 0;
  int                 n_fail = 0;
  int                 t0;

  mac_seq_ctrl_if bus ();

  mac_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .bus       (bus.slave),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_reset (mac_reset),
    .mac_out   (mac_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC model: input register plus MAC_LAT stages, sync active-high reset.
  logic [PSUM_BW-1:0] mst [MAC_LAT+1];

  function automatic logic [PSUM_BW-1:0] dot(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < PR; i++) s += $signed(a[i*BW +: BW]) * $signed(b[i*BW +: BW]);
    return s[PSUM_BW-1:0];
  endfunction

  always @(posedge clk) begin
    if (mac_reset) begin
      for (int i = 0; i <= MAC_LAT; i++) mst[i] <= '0;
    end else begin
      mst[0] <= dot(mac_a, mac_b);
      for (int i = 1; i <= MAC_LAT; i++) mst[i] <= mst[i-1];
    end
  end
  assign mac_out = mst[MAC_LAT];

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [OP_W-1:0] fill(input logic [BW-1:0] v);
    return {PR{v}};
  endfunction

  // All tasks start and end just after a negedge.
  task automatic do_start(input int n);
    start = 1'b1;
    len   = LEN_BW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int g;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g == 50) check("in_ready_wait", bus.in_ready, 1);
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
  endtask

  task automatic wait_res();
    int g;
    g = 0;
    while (!bus.res_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("res_valid_wait", bus.res_valid, 1);
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_reset", mac_reset, 1);
    reset = 1'b1;
    #1 check("rel_mac_reset_hold", mac_reset, 1);
    @(negedge clk);
    check("rel_mac_reset_drop", mac_reset, 0);

    // 1: single chunk, latency 7, result 8
    do_start(1);
    check("t1_in_ready", bus.in_ready, 1);
    send(fill(8'd1), fill(8'd1));
    t0 = cyc;
    idle_in();
    wait_res();
    check("t1_latency", cyc - t0, 7);
    check("t1_result", $signed(bus.result), 8);
    take_res();
    check("t1_idle", busy, 0);

    // 2: three back-to-back chunks, result 144
    do_start(3);
    send(fill(8'd2), fill(8'd3));
    t0 = cyc;
    send(fill(8'd2), fill(8'd3));
    send(fill(8'd2), fill(8'd3));
    check("t2_back_to_back", cyc - t0, 2);
    idle_in();
    check("t2_drain_in_ready", bus.in_ready, 0);
    check("t2_drain_busy", busy, 1);
    wait_res();
    check("t2_latency", cyc - t0, 9);
    check("t2_result", $signed(bus.result), 144);
    take_res();

    // 3: -128 * -128 with bubbles, result 524288
    do_start(4);
    for (int i = 0; i < 4; i++) begin
      send(fill(8'h80), fill(8'h80));
      if (i == 0) check("t3_mac_a_live", mac_a, fill(8'h80));
      idle_in();
      @(negedge clk);
      if (i == 0) check("t3_mac_a_gap", mac_a, 0);
    end
    wait_res();
    check("t3_result", $signed(bus.result), 524288);
    take_res();

    // 4: len=0 goes straight to DONE; start while busy is ignored
    do_start(0);
    check("t4_done_now", bus.res_valid, 1);
    check("t4_result", $signed(bus.result), 0);
    do_start(5);
    check("t4_still_done", bus.res_valid, 1);
    take_res();
    check("t4_no_restart", busy, 0);
    do_start(1);
    do_start(7);
    send(fill(8'd1), fill(8'd2));
    idle_in();
    check("t4_len_kept", bus.in_ready, 0);
    wait_res();
    check("t4_result2", $signed(bus.result), 16);
    take_res();

    // 5: result held while res_ready low; start ignored until after handshake
    do_start(1);
    send(fill(8'd3), fill(8'hFF));
    idle_in();
    wait_res();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd2;
      @(negedge clk);
      check("t5_hold_valid", bus.res_valid, 1);
      check("t5_hold_result", $signed(bus.result), -24);
    end
    start = 1'b1;
    len   = 8'd2;
    take_res();
    check("t5_start_on_hs_ignored", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("t5_start_after_hs", bus.in_ready, 1);
    send(fill(8'd1), fill(8'd1));
    send(fill(8'd1), fill(8'd1));
    idle_in();
    wait_res();
    check("t5_result", $signed(bus.result), 16);
    take_res();

    // 6: reset in the middle of a job
    do_start(5);
    send(fill(8'd1), fill(8'd1));
    send(fill(8'd1), fill(8'd1));
    idle_in();
    reset = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_in_ready", bus.in_ready, 0);
    check("t6_res_valid", bus.res_valid, 0);
    check("t6_result", bus.result, 0);
    check("t6_mac_a", mac_a, 0);
    check("t6_mac_reset", mac_reset, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_start(1);
    send(fill(8'd1), fill(8'hFF));
    idle_in();
    wait_res();
    check("t6_result_after", $signed(bus.result), -8);
    take_res();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
